gzip_trailer_checker: RTL
=========================

GZIP_TRAILER_CHECKER -- requirements
Module: gzip_trailer_checker

Interface
REQ-001 SHALL have no parameters; the trailer is fixed at 8 bytes: CRC32 then ISIZE, both little-endian.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_en  input  1  byte strobe; one byte accepted per cycle when high, no backpressure.
REQ-005 SHALL have port: i_trl  input  1  qualifies i_byte when i_en=1: 0 = decompressed data byte, 1 = gzip trailer byte.
REQ-006 SHALL have port: i_byte  input  8  byte value.
REQ-007 SHALL have port: o_done  output  1  one-cycle pulse: check result valid.
REQ-008 SHALL have port: o_crc_ok  output  1  received CRC32 equals computed CRC32.
REQ-009 SHALL have port: o_len_ok  output  1  received ISIZE equals computed length mod 2^32.
REQ-010 SHALL have port: o_fmt_err  output  1  trailer truncated by a data byte.
REQ-011 SHALL have port: o_stream_len  output  32  computed length of the finished stream.
REQ-012 SHALL have port: o_stream_crc  output  32  computed final CRC32 of the finished stream, already inverted.

Function
REQ-013 SHALL implement FSM states DATA and TRL, entering DATA at reset.
REQ-014 In DATA, an accepted byte with i_trl=0 SHALL update the length (+1, wraps at 2^32) and the CRC; the CRC SHALL start at 0xFFFFFFFF and use reflected poly 0xEDB88320, processing one byte per cycle.
REQ-015 In DATA, an accepted byte with i_trl=1 SHALL be stored as trailer byte 0, set the trailer counter to 1 and enter TRL, leaving length and CRC unchanged; a zero-length stream is therefore legal.
REQ-016 In TRL, an accepted byte with i_trl=1 SHALL be stored at position counter[2:0] and increment the counter.
REQ-017 On acceptance of trailer byte 7, the block SHALL, at the next edge, pulse o_done=1, register the result outputs, clear the accumulators (len=0, crc=0xFFFFFFFF) and return to DATA.
REQ-018 The registered results SHALL be: o_crc_ok = (trailer[3:0] as LE word == ~crc); o_len_ok = (trailer[7:4] as LE word == len); o_fmt_err=0.
REQ-019 A data byte accepted in the cycle immediately after trailer byte 7 SHALL be counted as byte 1 of the next stream, with no lost bytes.
REQ-020 In TRL, an accepted byte with i_trl=0 SHALL cause: o_done=1, o_fmt_err=1, o_crc_ok=0, o_len_ok=0 at the next edge.
REQ-021 In that case, o_stream_len and o_stream_crc SHALL show the aborted stream's values.
REQ-022 In that case, the accumulators SHALL restart with that byte counted as the first data byte of a new stream (len=1), and the FSM SHALL return to DATA.
REQ-023 i_en=0 cycles SHALL be allowed anywhere (within data or trailer) with no state change.
REQ-024 o_crc_ok, o_len_ok, o_fmt_err, o_stream_len and o_stream_crc SHALL hold until the next o_done pulse.
REQ-025 o_done SHALL be low in every other cycle.
REQ-026 Latency SHALL be exactly 1 cycle from the last trailer byte (or the truncating data byte) to o_done.

Reset
REQ-027 On rstn low, all outputs SHALL be 0, len=0, crc=0xFFFFFFFF, trailer counter=0, state=DATA, and the trailer buffer cleared.
REQ-028 Reset mid-stream or mid-trailer SHALL discard the partial stream, with no o_done pulse at or after release until a full trailer is seen.

Verification
REQ-029 Stream "123456789" (9 data bytes) followed by trailer 26 39 F4 CB 09 00 00 00 -> one o_done; o_crc_ok=1; o_len_ok=1; o_fmt_err=0; o_stream_crc=0xCBF43926; o_stream_len=9.
REQ-030 Empty stream, trailer 00 x8 -> o_done with o_crc_ok=1, o_len_ok=1, o_stream_len=0, o_stream_crc=0.
REQ-031 Same stream as REQ-029 with trailer CRC byte 0 = 0x27 -> o_crc_ok=0, o_len_ok=1; with ISIZE = 0x0A -> o_crc_ok=1, o_len_ok=0.
REQ-032 Trailer cut after 3 bytes by data 0x41 -> o_fmt_err=1, o_crc_ok=0, o_len_ok=0.
REQ-033 Continuing REQ-032: a following trailer with the CRC of "A" (0xD3D99E8B) and length 1 -> o_crc_ok=1, o_len_ok=1.
REQ-034 Back-to-back streams with i_en held high continuously, plus a random i_en-gap run, each checked against a software CRC32 model.
REQ-035 rstn pulsed mid-trailer -> no o_done pulse; all outputs 0; the next complete stream is checked correctly.

Source files
------------

// File: rtl/gzip_trailer_checker.sv
// gzip_trailer_checker
//
// Purpose:
//   Watches a decompressed gzip byte stream followed by its 8-byte trailer
//   (CRC32 then ISIZE, both little-endian). It computes the CRC32 and the
//   length of the data bytes as they arrive. When the last trailer byte is
//   accepted, it compares the received trailer against the computed values
//   and reports the result one cycle later. A trailer that is cut short by
//   a data byte is reported as a format error. That data byte becomes the
//   first byte of the next stream.
//
// Ports:
//   clk           clock, rising-edge active
//   rstn          asynchronous active-low reset
//   i_en          byte strobe, one byte per cycle, no backpressure
//   i_trl         qualifies i_byte: 0 = data byte, 1 = trailer byte
//   i_byte        byte value
//   o_done        one-cycle pulse, result outputs updated
//   o_crc_ok      received CRC32 matched the computed CRC32
//   o_len_ok      received ISIZE matched the computed length (mod 2^32)
//   o_fmt_err     trailer was truncated by a data byte
//   o_stream_len  computed length of the finished stream
//   o_stream_crc  computed final (inverted) CRC32 of the finished stream

module gzip_trailer_checker (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_en,
  input  logic        i_trl,
  input  logic [7:0]  i_byte,
  output logic        o_done,
  output logic        o_crc_ok,
  output logic        o_len_ok,
  output logic        o_fmt_err,
  output logic [31:0] o_stream_len,
  output logic [31:0] o_stream_crc
);

  typedef enum logic {
    DATA = 1'b0,
    TRL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] trl_q, trl_d;
  logic        done_q, done_d;
  logic        crcOk_q, crcOk_d;
  logic        lenOk_q, lenOk_d;
  logic        fmtErr_q, fmtErr_d;
  logic [31:0] streamLen_q, streamLen_d;
  logic [31:0] streamCrc_q, streamCrc_d;

  // Reflected CRC32 (poly 0xEDB88320) advanced by one byte, LSB first.
  function automatic logic [31:0] crcNext(input logic [31:0] crc,
                                          input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Next-state logic.
  // The trailer buffer is updated combinationally before the compare.
  // This lets the last trailer byte take part in the result in the cycle
  // it is accepted.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    trl_d       = trl_q;
    done_d      = 1'b0;
    crcOk_d     = crcOk_q;
    lenOk_d     = lenOk_q;
    fmtErr_d    = fmtErr_q;
    streamLen_d = streamLen_q;
    streamCrc_d = streamCrc_q;

    case (state_q)
      DATA: begin
        if (i_en) begin
          if (!i_trl) begin
            len_d = len_q + 32'd1;
            crc_d = crcNext(crc_q, i_byte);
          end else begin
            trl_d[7:0] = i_byte;
            cnt_d      = 3'd1;
            state_d    = TRL;
          end
        end
      end

      TRL: begin
        if (i_en) begin
          if (i_trl) begin
            trl_d[{cnt_q, 3'b000} +: 8] = i_byte;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              done_d      = 1'b1;
              crcOk_d     = (trl_d[31:0] == ~crc_q);
              lenOk_d     = (trl_d[63:32] == len_q);
              fmtErr_d    = 1'b0;
              streamLen_d = len_q;
              streamCrc_d = ~crc_q;
              len_d       = 32'd0;
              crc_d       = 32'hFFFFFFFF;
              state_d     = DATA;
            end
          end else begin
            // Truncated trailer: report the aborted stream.
            // The offending byte then starts a fresh stream.
            done_d      = 1'b1;
            fmtErr_d    = 1'b1;
            crcOk_d     = 1'b0;
            lenOk_d     = 1'b0;
            streamLen_d = len_q;
            streamCrc_d = ~crc_q;
            len_d       = 32'd1;
            crc_d       = crcNext(32'hFFFFFFFF, i_byte);
            cnt_d       = 3'd0;
            state_d     = DATA;
          end
        end
      end

      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= DATA;
      len_q       <= 32'd0;
      crc_q       <= 32'hFFFFFFFF;
      cnt_q       <= 3'd0;
      trl_q       <= 64'd0;
      done_q      <= 1'b0;
      crcOk_q     <= 1'b0;
      lenOk_q     <= 1'b0;
      fmtErr_q    <= 1'b0;
      streamLen_q <= 32'd0;
      streamCrc_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      trl_q       <= trl_d;
      done_q      <= done_d;
      crcOk_q     <= crcOk_d;
      lenOk_q     <= lenOk_d;
      fmtErr_q    <= fmtErr_d;
      streamLen_q <= streamLen_d;
      streamCrc_q <= streamCrc_d;
    end
  end

  assign o_done       = done_q;
  assign o_crc_ok     = crcOk_q;
  assign o_len_ok     = lenOk_q;
  assign o_fmt_err    = fmtErr_q;
  assign o_stream_len = streamLen_q;
  assign o_stream_crc = streamCrc_q;

endmodule
